// File: rtl/vanilla_stall_depend_profiler_pkg.sv
// Shared types for the dependency-stall profiler.
// Provides the scoreboard cause-bit structs consumed from the scoreboard
// tracker, the RV32 register-file geometry, the stall cause enumeration
// (listed in attribution priority order) and the read-port selector codes.
package vanilla_stall_profiler_pkg;

    localparam int unsigned RV32_reg_els_gp        = 32;
    localparam int unsigned RV32_reg_addr_width_gp = 5;

    // Per-register int scoreboard cause bits.
    typedef struct packed {
        logic idiv;
        logic remote_dram_amo;
        logic remote_dram_load;
        logic remote_dram_seq_load;
        logic remote_global_load;
        logic remote_group_load;
    } vanilla_isb_info_s;

    // Per-register float scoreboard cause bits.
    typedef struct packed {
        logic fdiv_fsqrt;
        logic remote_dram_load;
        logic remote_dram_seq_load;
        logic remote_global_load;
        logic remote_group_load;
    } vanilla_fsb_info_s;

    // Enumeration order is the attribution priority order.
    typedef enum logic [3:0] {
        CAUSE_INT_IDIV          = 4'd0,
        CAUSE_INT_DRAM_AMO      = 4'd1,
        CAUSE_INT_DRAM_LOAD     = 4'd2,
        CAUSE_INT_DRAM_SEQ_LOAD = 4'd3,
        CAUSE_INT_GLOBAL_LOAD   = 4'd4,
        CAUSE_INT_GROUP_LOAD    = 4'd5,
        CAUSE_FP_FDIV_FSQRT     = 4'd6,
        CAUSE_FP_DRAM_LOAD      = 4'd7,
        CAUSE_FP_DRAM_SEQ_LOAD  = 4'd8,
        CAUSE_FP_GLOBAL_LOAD    = 4'd9,
        CAUSE_FP_GROUP_LOAD     = 4'd10,
        CAUSE_OTHER             = 4'd11,
        CAUSE_NONE              = 4'd15
    } stall_cause_e;

    localparam int unsigned NUM_CAUSES = 12;

    localparam logic [1:0] READ_SEL_CYCLES   = 2'd0;
    localparam logic [1:0] READ_SEL_EPISODES = 2'd1;
    localparam logic [1:0] READ_SEL_MAX      = 2'd2;
    localparam logic [1:0] READ_SEL_RSVD     = 2'd3;

endpackage

// File: rtl/vanilla_stall_depend_profiler_if.sv
// Counter read port of the dependency-stall profiler.
// Signal names are from the profiler's point of view:
//   read_v_i / read_cause_i / read_sel_i : request (one per cycle, no back-pressure)
//   read_v_o / read_data_o               : registered response, one cycle later
interface vanilla_stall_depend_profiler_if #(
    parameter int counter_width_p = 32
);
    logic                       read_v_i;
    logic [3:0]                 read_cause_i;
    logic [1:0]                 read_sel_i;
    logic                       read_v_o;
    logic [counter_width_p-1:0] read_data_o;

    modport slave (
        input  read_v_i, read_cause_i, read_sel_i,
        output read_v_o, read_data_o
    );

    modport master (
        output read_v_i, read_cause_i, read_sel_i,
        input  read_v_o, read_data_o
    );
endinterface

// File: rtl/vanilla_stall_cause_decode.sv
// Combinational stall attribution.
// Ports: ID source register indices and read flags, int/float scoreboard
// cause vectors in; the single highest-priority stall cause out
// (CAUSE_OTHER when no cause bit is set on any read operand).
module vanilla_stall_cause_decode
    import vanilla_stall_profiler_pkg::*;
#(
    parameter int reg_addr_width_lp = RV32_reg_addr_width_gp
) (
    input  logic [reg_addr_width_lp-1:0]             id_rs1_i,
    input  logic [reg_addr_width_lp-1:0]             id_rs2_i,
    input  logic [reg_addr_width_lp-1:0]             id_rs3_i,
    input  logic                                     id_read_irs1_i,
    input  logic                                     id_read_irs2_i,
    input  logic                                     id_read_frs1_i,
    input  logic                                     id_read_frs2_i,
    input  logic                                     id_read_frs3_i,
    input  vanilla_isb_info_s [RV32_reg_els_gp-1:0]  int_sb_i,
    input  vanilla_fsb_info_s [RV32_reg_els_gp-1:0]  float_sb_i,
    output stall_cause_e                             cause_o
);

    vanilla_isb_info_s isb_acc;
    vanilla_fsb_info_s fsb_acc;

    always_comb begin
        isb_acc = '0;
        fsb_acc = '0;
        // x0 is never scoreboarded; any bits seen there are ignored.
        if (id_read_irs1_i && (id_rs1_i != '0))
            isb_acc = vanilla_isb_info_s'(isb_acc | int_sb_i[id_rs1_i]);
        if (id_read_irs2_i && (id_rs2_i != '0))
            isb_acc = vanilla_isb_info_s'(isb_acc | int_sb_i[id_rs2_i]);
        if (id_read_frs1_i)
            fsb_acc = vanilla_fsb_info_s'(fsb_acc | float_sb_i[id_rs1_i]);
        if (id_read_frs2_i)
            fsb_acc = vanilla_fsb_info_s'(fsb_acc | float_sb_i[id_rs2_i]);
        if (id_read_frs3_i)
            fsb_acc = vanilla_fsb_info_s'(fsb_acc | float_sb_i[id_rs3_i]);

        cause_o = CAUSE_OTHER;
        if      (isb_acc.idiv)                 cause_o = CAUSE_INT_IDIV;
        else if (isb_acc.remote_dram_amo)      cause_o = CAUSE_INT_DRAM_AMO;
        else if (isb_acc.remote_dram_load)     cause_o = CAUSE_INT_DRAM_LOAD;
        else if (isb_acc.remote_dram_seq_load) cause_o = CAUSE_INT_DRAM_SEQ_LOAD;
        else if (isb_acc.remote_global_load)   cause_o = CAUSE_INT_GLOBAL_LOAD;
        else if (isb_acc.remote_group_load)    cause_o = CAUSE_INT_GROUP_LOAD;
        else if (fsb_acc.fdiv_fsqrt)           cause_o = CAUSE_FP_FDIV_FSQRT;
        else if (fsb_acc.remote_dram_load)     cause_o = CAUSE_FP_DRAM_LOAD;
        else if (fsb_acc.remote_dram_seq_load) cause_o = CAUSE_FP_DRAM_SEQ_LOAD;
        else if (fsb_acc.remote_global_load)   cause_o = CAUSE_FP_GLOBAL_LOAD;
        else if (fsb_acc.remote_group_load)    cause_o = CAUSE_FP_GROUP_LOAD;
    end

endmodule

// File: rtl/vanilla_stall_depend_profiler.sv
// Dependency-stall profiler.
// Attributes every counting ID dependency-stall cycle to one cause and keeps,
// per cause, saturating counts of stall cycles, stall episodes and the longest
// closed episode. Counters are read back through rd_if (registered response).
// Ports: clk_i/reset_i (sync, active-high), stall_all_i, stall_depend_i,
// ID operand indices/read flags, int/float scoreboard vectors, clear_i,
// rd_if (read port), cur_cause_o (cause of the open episode, else CAUSE_NONE).
module vanilla_stall_depend_profiler
    import vanilla_stall_profiler_pkg::*;
#(
    parameter int counter_width_p   = 32,
    parameter int reg_addr_width_lp = RV32_reg_addr_width_gp
) (
    input  logic                                     clk_i,
    input  logic                                     reset_i,
    input  logic                                     stall_all_i,
    input  logic                                     stall_depend_i,
    input  logic [reg_addr_width_lp-1:0]             id_rs1_i,
    input  logic [reg_addr_width_lp-1:0]             id_rs2_i,
    input  logic [reg_addr_width_lp-1:0]             id_rs3_i,
    input  logic                                     id_read_irs1_i,
    input  logic                                     id_read_irs2_i,
    input  logic                                     id_read_frs1_i,
    input  logic                                     id_read_frs2_i,
    input  logic                                     id_read_frs3_i,
    input  vanilla_isb_info_s [RV32_reg_els_gp-1:0]  int_sb_i,
    input  vanilla_fsb_info_s [RV32_reg_els_gp-1:0]  float_sb_i,
    input  logic                                     clear_i,
    vanilla_stall_depend_profiler_if.slave           rd_if,
    output stall_cause_e                             cur_cause_o
);

    typedef enum logic {IDLE, IN_STALL} state_e;

    localparam logic [counter_width_p-1:0] CNT_MAX = '1;

    state_e                     state_q;
    stall_cause_e               cause_q;
    stall_cause_e               cause_d;
    logic [counter_width_p-1:0] len_q;
    logic [counter_width_p-1:0] cycles_q   [NUM_CAUSES];
    logic [counter_width_p-1:0] episodes_q [NUM_CAUSES];
    logic [counter_width_p-1:0] max_q      [NUM_CAUSES];
    logic                       read_v_q;
    logic [counter_width_p-1:0] read_data_q;
    logic [counter_width_p-1:0] read_data_d;

    vanilla_stall_cause_decode #(
        .reg_addr_width_lp (reg_addr_width_lp)
    ) decode (
        .id_rs1_i       (id_rs1_i),
        .id_rs2_i       (id_rs2_i),
        .id_rs3_i       (id_rs3_i),
        .id_read_irs1_i (id_read_irs1_i),
        .id_read_irs2_i (id_read_irs2_i),
        .id_read_frs1_i (id_read_frs1_i),
        .id_read_frs2_i (id_read_frs2_i),
        .id_read_frs3_i (id_read_frs3_i),
        .int_sb_i       (int_sb_i),
        .float_sb_i     (float_sb_i),
        .cause_o        (cause_d)
    );

    // FSM and counter arrays. clear_i takes precedence over counting;
    // stall_all_i freezes everything including an open episode.
    always_ff @(posedge clk_i) begin
        if (reset_i || clear_i) begin
            state_q <= IDLE;
            cause_q <= CAUSE_NONE;
            len_q   <= '0;
            for (int unsigned i = 0; i < NUM_CAUSES; i++) begin
                cycles_q[i]   <= '0;
                episodes_q[i] <= '0;
                max_q[i]      <= '0;
            end
        end else if (!stall_all_i) begin
            if (stall_depend_i) begin
                if (cycles_q[cause_d] != CNT_MAX)
                    cycles_q[cause_d] <= cycles_q[cause_d] + 1'b1;
                if (state_q == IN_STALL && cause_q == cause_d) begin
                    if (len_q != CNT_MAX)
                        len_q <= len_q + 1'b1;
                end else begin
                    // Close the previous episode (if any) and open a new one
                    // in the same cycle; the two touch different cause slots.
                    if (state_q == IN_STALL && len_q > max_q[cause_q])
                        max_q[cause_q] <= len_q;
                    if (episodes_q[cause_d] != CNT_MAX)
                        episodes_q[cause_d] <= episodes_q[cause_d] + 1'b1;
                    state_q <= IN_STALL;
                    cause_q <= cause_d;
                    len_q   <= counter_width_p'(1);
                end
            end else if (state_q == IN_STALL) begin
                if (len_q > max_q[cause_q])
                    max_q[cause_q] <= len_q;
                state_q <= IDLE;
                cause_q <= CAUSE_NONE;
            end
        end
    end

    // Read data reflects counter state before this cycle's update.
    always_comb begin
        read_data_d = '0;
        if (rd_if.read_cause_i < 4'(NUM_CAUSES)) begin
            case (rd_if.read_sel_i)
                READ_SEL_CYCLES:   read_data_d = cycles_q[rd_if.read_cause_i];
                READ_SEL_EPISODES: read_data_d = episodes_q[rd_if.read_cause_i];
                READ_SEL_MAX:      read_data_d = max_q[rd_if.read_cause_i];
                default:           read_data_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            read_v_q    <= 1'b0;
            read_data_q <= '0;
        end else begin
            read_v_q    <= rd_if.read_v_i;
            read_data_q <= read_data_d;
        end
    end

    assign rd_if.read_v_o    = read_v_q;
    assign rd_if.read_data_o = read_data_q;
    assign cur_cause_o       = cause_q;

endmodule

// File: tb/tb_vanilla_stall_depend_profiler.sv
module tb_vanilla_stall_depend_profiler;
    import vanilla_stall_profiler_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_i, stall_all, stall_dep, clear;
    logic [4:0] rs1, rs2, rs3;
    logic irs1, irs2, frs1, frs2, frs3;
    vanilla_isb_info_s [31:0] isb;
    vanilla_fsb_info_s [31:0] fsb;
    logic       rd_v;
    logic [3:0] rd_cause;
    logic [1:0] rd_sel;
    stall_cause_e cur32, cur4;

    int n_tests, n_fail;

    vanilla_stall_depend_profiler_if #(.counter_width_p(32)) if32 ();
    vanilla_stall_depend_profiler_if #(.counter_width_p(4))  if4 ();

    assign if32.read_v_i = rd_v;  assign if32.read_cause_i = rd_cause;  assign if32.read_sel_i = rd_sel;
    assign if4.read_v_i  = rd_v;  assign if4.read_cause_i  = rd_cause;  assign if4.read_sel_i  = rd_sel;

    vanilla_stall_depend_profiler #(.counter_width_p(32)) dut32 (
        .clk_i(clk), .reset_i(reset_i), .stall_all_i(stall_all), .stall_depend_i(stall_dep),
        .id_rs1_i(rs1), .id_rs2_i(rs2), .id_rs3_i(rs3),
        .id_read_irs1_i(irs1), .id_read_irs2_i(irs2),
        .id_read_frs1_i(frs1), .id_read_frs2_i(frs2), .id_read_frs3_i(frs3),
        .int_sb_i(isb), .float_sb_i(fsb), .clear_i(clear), .rd_if(if32), .cur_cause_o(cur32)
    );

    vanilla_stall_depend_profiler #(.counter_width_p(4)) dut4 (
        .clk_i(clk), .reset_i(reset_i), .stall_all_i(stall_all), .stall_depend_i(stall_dep),
        .id_rs1_i(rs1), .id_rs2_i(rs2), .id_rs3_i(rs3),
        .id_read_irs1_i(irs1), .id_read_irs2_i(irs2),
        .id_read_frs1_i(frs1), .id_read_frs2_i(frs2), .id_read_frs3_i(frs3),
        .int_sb_i(isb), .float_sb_i(fsb), .clear_i(clear), .rd_if(if4), .cur_cause_o(cur4)
    );

    typedef struct {
        logic [3:0]  cause;
        logic [1:0]  sel;
        logic [31:0] exp;
    } rd_vec_t;

    rd_vec_t tbl[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic do_read(input bit use4, input logic [3:0] c, input logic [1:0] s,
                           input logic [31:0] exp, input string nm);
        logic        v;
        logic [31:0] d;
        rd_v = 1'b1; rd_cause = c; rd_sel = s;
        @(posedge clk); #1;
        rd_v = 1'b0;
        v = use4 ? if4.read_v_o : if32.read_v_o;
        d = use4 ? {28'b0, if4.read_data_o} : if32.read_data_o;
        n_tests++;
        if (!v || d !== exp) begin
            n_fail++;
            $display("FAIL %s (cause %0d sel %0d): got valid=%0b data=%0d expected valid=1 data=%0d",
                     nm, c, s, v, d, exp);
        end
    endtask

    task automatic clr_inputs();
        stall_dep = 1'b0; stall_all = 1'b0;
        rs1 = '0; rs2 = '0; rs3 = '0;
        irs1 = 1'b0; irs2 = 1'b0; frs1 = 1'b0; frs2 = 1'b0; frs3 = 1'b0;
        isb = '0; fsb = '0;
    endtask

    task automatic run_stall(input int n);
        stall_dep = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic release_stall();
        stall_dep = 1'b0;
        @(posedge clk); #1;
        clr_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0; n_fail = 0;
        clr_inputs();
        clear = 1'b0; rd_v = 1'b0; rd_cause = '0; rd_sel = '0;
        reset_i = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset_i = 1'b0;

        check("rst_read_v", {31'b0, if32.read_v_o}, 32'd0);
        check("rst_read_data", if32.read_data_o, 32'd0);
        check("rst_cur_cause", {28'b0, cur32}, {28'b0, CAUSE_NONE});
        check("rst_cur_cause_w4", {28'b0, cur4}, {28'b0, CAUSE_NONE});

        // 1: int DRAM load on x5, 7 cycles; max stays 0 while the episode is open
        isb[5].remote_dram_load = 1'b1; rs1 = 5'd5; irs1 = 1'b1;
        run_stall(1);
        check("t1_cur_cause_open", {28'b0, cur32}, {28'b0, CAUSE_INT_DRAM_LOAD});
        do_read(1'b0, CAUSE_INT_DRAM_LOAD, READ_SEL_MAX, 32'd0, "t1_open_max");
        run_stall(5);
        release_stall();
        check("t1_cur_cause_closed", {28'b0, cur32}, {28'b0, CAUSE_NONE});

        // 2: int idiv beats fp fdiv
        isb[3].idiv = 1'b1; rs1 = 5'd3; irs1 = 1'b1;
        fsb[4].fdiv_fsqrt = 1'b1; rs2 = 5'd4; frs2 = 1'b1;
        run_stall(3);
        release_stall();

        // 3: cause switch mid-stall without a gap
        fsb[10].remote_group_load = 1'b1; rs1 = 5'd10; frs1 = 1'b1;
        run_stall(4);
        fsb[10].remote_group_load = 1'b0; fsb[10].remote_dram_seq_load = 1'b1;
        run_stall(2);
        check("t3_cur_cause_switched", {28'b0, cur32}, {28'b0, CAUSE_FP_DRAM_SEQ_LOAD});
        release_stall();

        // 4: stall_all freezes an open episode
        isb[9].remote_global_load = 1'b1; rs2 = 5'd9; irs2 = 1'b1;
        run_stall(2);
        stall_all = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("t4_cur_cause_frozen", {28'b0, cur32}, {28'b0, CAUSE_INT_GLOBAL_LOAD});
        stall_all = 1'b0;
        run_stall(2);
        release_stall();

        // 5: x0-only read, then a read operand with no scoreboard bits
        isb[0] = '1; rs1 = 5'd0; rs2 = 5'd0; irs1 = 1'b1; irs2 = 1'b1;
        run_stall(5);
        release_stall();
        rs1 = 5'd7; irs1 = 1'b1; frs1 = 1'b1;
        run_stall(3);
        release_stall();

        tbl.push_back('{CAUSE_INT_DRAM_LOAD,    READ_SEL_CYCLES,   32'd7});
        tbl.push_back('{CAUSE_INT_DRAM_LOAD,    READ_SEL_EPISODES, 32'd1});
        tbl.push_back('{CAUSE_INT_DRAM_LOAD,    READ_SEL_MAX,      32'd7});
        tbl.push_back('{CAUSE_INT_IDIV,         READ_SEL_CYCLES,   32'd3});
        tbl.push_back('{CAUSE_INT_IDIV,         READ_SEL_EPISODES, 32'd1});
        tbl.push_back('{CAUSE_INT_IDIV,         READ_SEL_MAX,      32'd3});
        tbl.push_back('{CAUSE_FP_FDIV_FSQRT,    READ_SEL_CYCLES,   32'd0});
        tbl.push_back('{CAUSE_FP_FDIV_FSQRT,    READ_SEL_EPISODES, 32'd0});
        tbl.push_back('{CAUSE_FP_GROUP_LOAD,    READ_SEL_CYCLES,   32'd4});
        tbl.push_back('{CAUSE_FP_GROUP_LOAD,    READ_SEL_EPISODES, 32'd1});
        tbl.push_back('{CAUSE_FP_GROUP_LOAD,    READ_SEL_MAX,      32'd4});
        tbl.push_back('{CAUSE_FP_DRAM_SEQ_LOAD, READ_SEL_CYCLES,   32'd2});
        tbl.push_back('{CAUSE_FP_DRAM_SEQ_LOAD, READ_SEL_EPISODES, 32'd1});
        tbl.push_back('{CAUSE_FP_DRAM_SEQ_LOAD, READ_SEL_MAX,      32'd2});
        tbl.push_back('{CAUSE_INT_GLOBAL_LOAD,  READ_SEL_CYCLES,   32'd4});
        tbl.push_back('{CAUSE_INT_GLOBAL_LOAD,  READ_SEL_EPISODES, 32'd1});
        tbl.push_back('{CAUSE_INT_GLOBAL_LOAD,  READ_SEL_MAX,      32'd4});
        tbl.push_back('{CAUSE_OTHER,            READ_SEL_CYCLES,   32'd8});
        tbl.push_back('{CAUSE_OTHER,            READ_SEL_EPISODES, 32'd2});
        tbl.push_back('{CAUSE_OTHER,            READ_SEL_MAX,      32'd5});
        tbl.push_back('{CAUSE_INT_DRAM_AMO,     READ_SEL_CYCLES,   32'd0});
        tbl.push_back('{CAUSE_INT_DRAM_LOAD,    READ_SEL_RSVD,     32'd0});
        tbl.push_back('{4'd12,                  READ_SEL_CYCLES,   32'd0});
        tbl.push_back('{4'd15,                  READ_SEL_EPISODES, 32'd0});

        // Back-to-back reads, one per cycle
        for (int i = 0; i < tbl.size(); i++)
            do_read(1'b0, tbl[i].cause, tbl[i].sel, tbl[i].exp, $sformatf("tbl[%0d]", i));
        check("read_v_drops", {31'b0, if32.read_v_o}, 32'd1);
        @(posedge clk); #1;
        check("read_v_idle", {31'b0, if32.read_v_o}, 32'd0);

        // clear beats a same-cycle counting event
        isb[5].remote_dram_load = 1'b1; rs1 = 5'd5; irs1 = 1'b1;
        stall_dep = 1'b1; clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        clr_inputs();
        check("clr_cur_cause", {28'b0, cur32}, {28'b0, CAUSE_NONE});
        do_read(1'b0, CAUSE_INT_DRAM_LOAD, READ_SEL_CYCLES, 32'd0, "clr_cycles");
        do_read(1'b0, CAUSE_OTHER, READ_SEL_CYCLES, 32'd0, "clr_other_cycles");

        // 6: saturation on the 4-bit instance
        isb[5].remote_dram_load = 1'b1; rs1 = 5'd5; irs1 = 1'b1;
        run_stall(20);
        release_stall();
        do_read(1'b1, CAUSE_INT_DRAM_LOAD, READ_SEL_CYCLES,   32'd15, "t6_w4_cycles");
        do_read(1'b1, CAUSE_INT_DRAM_LOAD, READ_SEL_EPISODES, 32'd1,  "t6_w4_episodes");
        do_read(1'b1, CAUSE_INT_DRAM_LOAD, READ_SEL_MAX,      32'd15, "t6_w4_max");
        do_read(1'b0, CAUSE_INT_DRAM_LOAD, READ_SEL_CYCLES,   32'd20, "t6_w32_cycles");
        do_read(1'b0, CAUSE_INT_DRAM_LOAD, READ_SEL_MAX,      32'd20, "t6_w32_max");
        clear = 1'b1;
        do_read(1'b1, CAUSE_INT_DRAM_LOAD, READ_SEL_CYCLES, 32'd15, "t6_read_with_clear");
        clear = 1'b0;
        do_read(1'b1, CAUSE_INT_DRAM_LOAD, READ_SEL_CYCLES, 32'd0,  "t6_read_after_clear");

        // reset mid-episode discards it
        isb[3].idiv = 1'b1; rs1 = 5'd3; irs1 = 1'b1;
        run_stall(3);
        check("rst_mid_cur_cause_open", {28'b0, cur32}, {28'b0, CAUSE_INT_IDIV});
        reset_i = 1'b1;
        @(posedge clk); #1;
        reset_i = 1'b0;
        clr_inputs();
        check("rst_mid_cur_cause", {28'b0, cur32}, {28'b0, CAUSE_NONE});
        do_read(1'b0, CAUSE_INT_IDIV, READ_SEL_CYCLES,   32'd0, "rst_mid_cycles");
        do_read(1'b0, CAUSE_INT_IDIV, READ_SEL_EPISODES, 32'd0, "rst_mid_episodes");
        do_read(1'b0, CAUSE_INT_IDIV, READ_SEL_MAX,      32'd0, "rst_mid_max");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
